// File: rtl/pic_inta_sequencer_if.sv
// Bus between the INTA sequencer, the 8259 PIC (INT/INTA/D) and the CPU core (vector handshake).
interface pic_inta_sequencer_if;
    logic       INT;
    logic       ien;
    logic [7:0] D;
    logic       INTA;
    logic [7:0] vec;
    logic       vec_valid;
    logic       vec_ready;
    logic       busy;
    logic       spurious;

    modport master (
        input  INT, ien, D, vec_ready,
        output INTA, vec, vec_valid, busy, spurious
    );

    modport slave (
        output INT, ien, D, vec_ready,
        input  INTA, vec, vec_valid, busy, spurious
    );
endinterface

// File: rtl/pic_inta_sequencer.sv
// Interrupt acknowledge sequencer: synchronizes INT, drives two INTA pulses, captures the vector.
// Optional macro PIC_INTA_SPURIOUS_EN aborts to COOL with a spurious strobe if int_s has dropped by ARM.
module pic_inta_sequencer #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pic_inta_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        P1,
        GAP,
        P2,
        HOLD,
        COOL
    } state_t;

    // Counter reloads with (length - 1) so a phase ends on the edge where it reads zero.
    localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_RELOAD   = 8'(GAP_LEN - 1);
    localparam logic [7:0] COOL_RELOAD  = 8'd1;

    state_t     state;
    logic [7:0] cnt;
    logic       sync1;
    logic       int_s;
    logic       inta;
    logic [7:0] vec;
    logic       vec_valid;
    logic       busy;
`ifdef PIC_INTA_SPURIOUS_EN
    logic       spurious;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            int_s <= 1'b0;
        end else begin
            sync1 <= bus.INT;
            int_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            inta      <= 1'b1;
            vec       <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef PIC_INTA_SPURIOUS_EN
            spurious  <= 1'b0;
`endif
        end else begin
`ifdef PIC_INTA_SPURIOUS_EN
            spurious <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (int_s && bus.ien) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
`ifdef PIC_INTA_SPURIOUS_EN
                    if (!int_s) begin
                        state    <= COOL;
                        cnt      <= COOL_RELOAD;
                        spurious <= 1'b1;
                    end else begin
                        state <= P1;
                        cnt   <= PULSE_RELOAD;
                        inta  <= 1'b0;
                    end
`else
                    state <= P1;
                    cnt   <= PULSE_RELOAD;
                    inta  <= 1'b0;
`endif
                end
                P1: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GAP_RELOAD;
                        inta  <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= P2;
                        cnt   <= PULSE_RELOAD;
                        inta  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                P2: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        inta      <= 1'b1;
                        vec       <= bus.D;
                        vec_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (vec_valid && bus.vec_ready) begin
                        state     <= COOL;
                        cnt       <= COOL_RELOAD;
                        vec_valid <= 1'b0;
                    end
                end
                COOL: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    inta  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INTA      = inta;
    assign bus.vec       = vec;
    assign bus.vec_valid = vec_valid;
    assign bus.busy      = busy;
`ifdef PIC_INTA_SPURIOUS_EN
    assign bus.spurious  = spurious;
`else
    assign bus.spurious  = 1'b0;
`endif

endmodule
